// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Issues layer_number tokens 0..LAYER_MAX for every accepted start request.
//   The number of issued tokens that have no matching layer_done yet is capped
//   at MAX_OUTSTANDING. Once the done for every layer has arrived, the block
//   raises sample_done and increments the completed-sample counter.
//
// Ports
//   clk, rst                   clock (rising edge), async active-low reset
//   start_valid/start_ready    sample request handshake
//   layer_number[_valid/ready] layer token stream
//   layer_done_valid/ready     one handshake per finished layer
//   sample_done_valid/ready    sample completion handshake
//   sample_count               samples completed since reset (wraps)
//   busy                       high whenever a sample is in progress
module layer_sequencer #(
    parameter int LAYER_ADDR_WIDTH = 2,
    parameter int LAYER_MAX        = 3,
    parameter int MAX_OUTSTANDING  = 1,
    parameter int SAMPLE_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    output logic [LAYER_ADDR_WIDTH-1:0] layer_number,
    output logic                        layer_number_valid,
    input  logic                        layer_number_ready,
    input  logic                        layer_done_valid,
    output logic                        layer_done_ready,
    output logic                        sample_done_valid,
    input  logic                        sample_done_ready,
    output logic [SAMPLE_CNT_WIDTH-1:0] sample_count,
    output logic                        busy
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0]          OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAST   = LAYER_ADDR_WIDTH'(LAYER_MAX);
    localparam logic [LAYER_ADDR_WIDTH:0]   ALL_DONE = (LAYER_ADDR_WIDTH + 1)'(LAYER_MAX + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                      state;
    logic [LAYER_ADDR_WIDTH-1:0] issue_ptr;
    logic [LAYER_ADDR_WIDTH:0]   done_cnt;
    logic [OUT_W-1:0]            outstanding;

    logic issue_hs;
    logic done_hs;

    // All outputs decode registered state only, so no valid depends on its ready.
    assign start_ready        = (state == IDLE);
    assign layer_number       = (state == RUN) ? issue_ptr : '0;
    assign layer_number_valid = (state == RUN) && (outstanding < OUT_MAX);
    // Done tokens are only accepted against an outstanding issue; anything else
    // is held off rather than dropped.
    assign layer_done_ready   = ((state == RUN) || (state == FLUSH)) && (outstanding != '0);
    assign sample_done_valid  = (state == DONE);
    assign busy               = (state != IDLE);

    assign issue_hs = layer_number_valid && layer_number_ready;
    assign done_hs  = layer_done_valid && layer_done_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            issue_ptr    <= '0;
            done_cnt     <= '0;
            outstanding  <= '0;
            sample_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        state       <= RUN;
                        issue_ptr   <= '0;
                        done_cnt    <= '0;
                        outstanding <= '0;
                    end
                end
                RUN, FLUSH: begin
                    if (issue_hs) begin
                        issue_ptr <= issue_ptr + 1'b1;
                        if (issue_ptr == LAST) state <= FLUSH;
                    end
                    // Simultaneous issue and done leave the outstanding count alone.
                    if (issue_hs && !done_hs)      outstanding <= outstanding + 1'b1;
                    else if (!issue_hs && done_hs) outstanding <= outstanding - 1'b1;
                    if (done_hs) begin
                        done_cnt <= done_cnt + 1'b1;
                        // The last done can only follow the last issue, hence FLUSH.
                        if ((state == FLUSH) && (done_cnt + 1'b1 == ALL_DONE)) state <= DONE;
                    end
                end
                DONE: begin
                    if (sample_done_ready) begin
                        sample_count <= sample_count + 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer. Instance 0: MAX_OUTSTANDING=1, 2-bit sample
// counter. Instance 1: MAX_OUTSTANDING=2, 16-bit sample counter. A sample-level
// model (issued/done layer counts, active/pending flags) predicts every output.
module tb_layer_sequencer;

    localparam int LM = 3;

    logic clk = 0;
    logic rst = 1;
    logic [1:0] sv = '0, lnr = '0, man_ldv = '0, sdr = '0, rsp_en = '0;
    wire  [1:0] ldv;
    wire  [1:0] sr, lnv, ldr, sdv, busy;
    wire  [1:0] ln0, ln1;
    wire  [1:0] sc0;
    wire  [15:0] sc1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tok0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layer_sequencer #(.LAYER_ADDR_WIDTH(2), .LAYER_MAX(LM), .MAX_OUTSTANDING(1), .SAMPLE_CNT_WIDTH(2)) dut0 (
        .clk(clk), .rst(rst),
        .start_valid(sv[0]), .start_ready(sr[0]),
        .layer_number(ln0), .layer_number_valid(lnv[0]), .layer_number_ready(lnr[0]),
        .layer_done_valid(ldv[0]), .layer_done_ready(ldr[0]),
        .sample_done_valid(sdv[0]), .sample_done_ready(sdr[0]),
        .sample_count(sc0), .busy(busy[0])
    );

    layer_sequencer #(.LAYER_ADDR_WIDTH(2), .LAYER_MAX(LM), .MAX_OUTSTANDING(2), .SAMPLE_CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst),
        .start_valid(sv[1]), .start_ready(sr[1]),
        .layer_number(ln1), .layer_number_valid(lnv[1]), .layer_number_ready(lnr[1]),
        .layer_done_valid(ldv[1]), .layer_done_ready(ldr[1]),
        .sample_done_valid(sdv[1]), .sample_done_ready(sdr[1]),
        .sample_count(sc1), .busy(busy[1])
    );

    // Responder: answers each accepted token with a done about 4 cycles later.
    for (genvar g = 0; g < 2; g++) begin : rsp
        int   q[$];
        logic rd;
        assign ldv[g] = rd | man_ldv[g];
        always @(posedge clk or negedge rst) begin
            if (!rst || !rsp_en[g]) begin
                q.delete();
                rd <= 1'b0;
            end else begin
                if (rd && ldr[g]) void'(q.pop_front());
                if (lnv[g] && lnr[g]) q.push_back(cyc + 4);
                rd <= (q.size() != 0) && (q[0] <= cyc);
            end
        end
    end

    always @(posedge clk) if (rst && lnv[0] && lnr[0]) tok0.push_back(int'(ln0));

    // ---------------- sample-level model ----------------
    int m_iss[2], m_done[2], m_cnt[2];
    bit m_act[2], m_pend[2];

    function automatic int mo(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int cmod(input int i);
        return (i == 0) ? 4 : 65536;
    endfunction

    function automatic void model_out(input int i, output bit e_sr, output bit e_lnv,
                                      output bit e_ldr, output bit e_sdv, output bit e_busy,
                                      output int e_ln);
        int  o;
        bit  issuing;
        o       = m_iss[i] - m_done[i];
        issuing = m_act[i] && (m_iss[i] <= LM);
        e_sr    = !m_act[i] && !m_pend[i];
        e_lnv   = issuing && (o < mo(i));
        e_ln    = issuing ? m_iss[i] : 0;
        e_ldr   = m_act[i] && (o > 0);
        e_sdv   = m_pend[i];
        e_busy  = m_act[i] || m_pend[i];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_iss[i] <= 0; m_done[i] <= 0; m_cnt[i] <= 0;
                m_act[i] <= 0; m_pend[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit e_sr, e_lnv, e_ldr, e_sdv, e_busy;
                int e_ln, ni, nd;
                model_out(i, e_sr, e_lnv, e_ldr, e_sdv, e_busy, e_ln);
                if (e_sr) begin
                    if (sv[i]) begin
                        m_act[i] <= 1; m_iss[i] <= 0; m_done[i] <= 0;
                    end
                end else if (m_act[i]) begin
                    ni = m_iss[i] + int'(e_lnv && lnr[i]);
                    nd = m_done[i] + int'(e_ldr && ldv[i]);
                    m_iss[i]  <= ni;
                    m_done[i] <= nd;
                    if (nd == LM + 1) begin
                        m_act[i] <= 0; m_pend[i] <= 1;
                    end
                end else if (m_pend[i] && sdr[i]) begin
                    m_pend[i] <= 0;
                    m_cnt[i]  <= (m_cnt[i] + 1) % cmod(i);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            bit e_sr, e_lnv, e_ldr, e_sdv, e_busy;
            int e_ln;
            model_out(i, e_sr, e_lnv, e_ldr, e_sdv, e_busy, e_ln);
            chk($sformatf("%s%0d start_ready", tag, i), int'(sr[i]), int'(e_sr));
            chk($sformatf("%s%0d ln_valid", tag, i), int'(lnv[i]), int'(e_lnv));
            chk($sformatf("%s%0d layer_number", tag, i), (i == 0) ? int'(ln0) : int'(ln1), e_ln);
            chk($sformatf("%s%0d done_ready", tag, i), int'(ldr[i]), int'(e_ldr));
            chk($sformatf("%s%0d sample_done", tag, i), int'(sdv[i]), int'(e_sdv));
            chk($sformatf("%s%0d busy", tag, i), int'(busy[i]), int'(e_busy));
            chk($sformatf("%s%0d sample_count", tag, i), (i == 0) ? int'(sc0) : int'(sc1), m_cnt[i]);
        end
    endtask

    always @(negedge clk) compare_all("cyc");

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int i);
        sv[i] = 1'b1;
        tick(1);
        sv[i] = 1'b0;
    endtask

    task automatic wait_sdv(input int i, input string nm);
        int n = 0;
        while (!sdv[i] && n < 200) begin
            tick(1);
            n++;
        end
        chk({nm, " sample_done seen"}, int'(sdv[i]), 1);
    endtask

    initial begin
        #1 rst = 1'b0;
        tick(2);
        chk("reset start_ready", int'(sr[0]), 1);
        chk("reset busy", int'(busy[0]), 0);
        chk("reset layer_number", int'(ln0), 0);
        rst = 1'b1;
        lnr = 2'b11;
        sdr = 2'b11;
        tick(1);

        // T2: two tokens in flight on instance 1
        rsp_en[1] = 1'b1;
        start(1);
        chk("T2 layer0 valid", int'(lnv[1]), 1);
        chk("T2 layer0 number", int'(ln1), 0);
        tick(1);
        chk("T2 layer1 back-to-back", int'(lnv[1]) * 10 + int'(ln1), 11);
        tick(1);
        chk("T2 layer2 held", int'(lnv[1]), 0);
        wait_sdv(1, "T2");
        tick(1);
        chk("T2 sample_count", int'(sc1), 1);
        rsp_en[1] = 1'b0;

        // T1: one token at a time on instance 0
        rsp_en[0] = 1'b1;
        tok0.delete();
        start(0);
        wait_sdv(0, "T1");
        tick(1);
        chk("T1 token count", tok0.size(), 4);
        for (int k = 0; k < 4 && k < tok0.size(); k++) chk($sformatf("T1 token%0d", k), tok0[k], k);
        chk("T1 sample_count", int'(sc0), 1);

        // T3: downstream stall holds the token
        lnr[0] = 1'b0;
        start(0);
        for (int k = 0; k < 5; k++) begin
            chk("T3 held valid", int'(lnv[0]), 1);
            chk("T3 held number", int'(ln0), 0);
            tick(1);
        end
        lnr[0] = 1'b1;
        wait_sdv(0, "T3");
        tick(1);
        chk("T3 sample_count", int'(sc0), 2);

        // T4: stray done token stalled until a layer is outstanding
        rsp_en[0]  = 1'b0;
        man_ldv[0] = 1'b1;
        tick(3);
        chk("T4 idle done_ready", int'(ldr[0]), 0);
        start(0);
        wait_sdv(0, "T4");
        man_ldv[0] = 1'b0;
        tick(1);
        chk("T4 sample_count", int'(sc0), 3);

        // T5: async reset mid-sample
        rsp_en[0] = 1'b1;
        tok0.delete();
        start(0);
        for (int n = 0; n < 50 && tok0.size() < 2; n++) tick(1);
        chk("T5 two tokens issued", tok0.size(), 2);
        #1 rst = 1'b0;
        #1;
        chk("T5 async start_ready", int'(sr[0]), 1);
        chk("T5 async busy", int'(busy[0]), 0);
        chk("T5 async sample_count", int'(sc0), 0);
        compare_all("T5 ");
        tick(1);
        rst = 1'b1;
        tick(1);
        start(0);
        chk("T5 restart layer0", int'(lnv[0]) * 10 + int'(ln0), 10);
        wait_sdv(0, "T5");
        tick(1);
        chk("T5 sample_count", int'(sc0), 1);

        // T6: sample_done held, then counter wrap
        sdr[0] = 1'b0;
        start(0);
        wait_sdv(0, "T6");
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("T6 done held", int'(sdv[0]), 1);
            chk("T6 start_ready low", int'(sr[0]), 0);
        end
        sdr[0] = 1'b1;
        tick(1);
        chk("T6 sample_count 2", int'(sc0), 2);
        start(0);
        wait_sdv(0, "T6b");
        tick(1);
        chk("T6 sample_count 3", int'(sc0), 3);
        start(0);
        wait_sdv(0, "T6c");
        tick(1);
        chk("T6 sample_count wrap", int'(sc0), 0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
